// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS parameter-link types for sender and receiver
package dds_pkg;

  localparam int FREQ_W = 48;
  localparam int RATE_W = 32;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] delta_freq;
    logic [RATE_W-1:0] delta_rate;
  } dds_param_t;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for one asynchronous level
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/dds_chirp_rx.sv
// rtl/dds_chirp_rx.sv - DDS-domain REQ/ACK parameter receiver and linear-FM chirp engine
module dds_chirp_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FREQ_W      = dds_pkg::FREQ_W,
  parameter int RATE_W      = dds_pkg::RATE_W,
  parameter int PHASE_OUT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   REQ,
  output logic                   ACK,
  input  logic [FREQ_W-1:0]      DDS_freq,
  input  logic [FREQ_W-1:0]      DDS_delta_freq,
  input  logic [RATE_W-1:0]      DDS_delta_rate,
  input  logic                   DDS_START,
  output logic                   RUN,
  output logic [FREQ_W-1:0]      FREQ_WORD,
  output logic [PHASE_OUT_W-1:0] PHASE_OUT,
  output logic                   PARAM_NEW
);

  import dds_pkg::*;

  logic              req_s;
  logic              start_s;
  logic              start_d;
  logic              start_rise;
  hs_state_t         state;
  dds_param_t        shadow;
  dds_param_t        active;
  logic [FREQ_W-1:0] phase;
  logic [RATE_W-1:0] rate_cnt;
  logic              run_q;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .CLK    (CLK),
    .RESETn (RESETn),
    .d      (REQ),
    .q      (req_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .CLK    (CLK),
    .RESETn (RESETn),
    .d      (DDS_START),
    .q      (start_s)
  );

  assign start_rise = start_s & ~start_d;

  // The bus is only trusted once req_s is high, so it is sampled on the IDLE->ACK edge alone.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= H_IDLE;
      ACK       <= 1'b0;
      PARAM_NEW <= 1'b0;
      shadow    <= '0;
    end else begin
      PARAM_NEW <= 1'b0;
      ACK       <= (state == H_ACK);
      case (state)
        H_IDLE: begin
          if (req_s) begin
            shadow.freq       <= DDS_freq;
            shadow.delta_freq <= DDS_delta_freq;
            shadow.delta_rate <= DDS_delta_rate;
            PARAM_NEW         <= 1'b1;
            state             <= H_ACK;
          end
        end
        H_ACK: begin
          if (!req_s) begin
            state <= H_IDLE;
          end
        end
        default: state <= H_IDLE;
      endcase
    end
  end

  // A start edge loads the shadow set seen before this edge, so a same-cycle capture waits for the next start.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      start_d  <= 1'b0;
      run_q    <= 1'b0;
      active   <= '0;
      phase    <= '0;
      rate_cnt <= '0;
    end else begin
      start_d <= start_s;
      if (start_rise) begin
        run_q    <= 1'b1;
        active   <= shadow;
        phase    <= '0;
        rate_cnt <= shadow.delta_rate;
      end else if (!start_s) begin
        run_q <= 1'b0;
        phase <= '0;
      end else if (run_q) begin
        phase <= phase + active.freq;
        if (active.delta_rate != '0) begin
          if (rate_cnt == RATE_W'(1)) begin
            active.freq <= active.freq + active.delta_freq;
            rate_cnt    <= active.delta_rate;
          end else begin
            rate_cnt <= rate_cnt - RATE_W'(1);
          end
        end
      end
    end
  end

  assign RUN       = run_q;
  assign FREQ_WORD = active.freq;
  assign PHASE_OUT = phase[FREQ_W-1 -: PHASE_OUT_W];

endmodule

// File: tb/tb_dds_chirp_rx.sv
// tb/tb_dds_chirp_rx.sv - self-checking bench for dds_chirp_rx
module tb_dds_chirp_rx;

  localparam int FW = 48;
  localparam int RW = 32;
  localparam int PW = 16;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          REQ = 1'b0;
  logic          DDS_START = 1'b0;
  logic [FW-1:0] DDS_freq = '0;
  logic [FW-1:0] DDS_delta_freq = '0;
  logic [RW-1:0] DDS_delta_rate = '0;
  logic          ACK;
  logic          RUN;
  logic          PARAM_NEW;
  logic [FW-1:0] FREQ_WORD;
  logic [PW-1:0] PHASE_OUT;

  dds_chirp_rx #(
    .SYNC_STAGES (2),
    .FREQ_W      (FW),
    .RATE_W      (RW),
    .PHASE_OUT_W (PW)
  ) dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .REQ            (REQ),
    .ACK            (ACK),
    .DDS_freq       (DDS_freq),
    .DDS_delta_freq (DDS_delta_freq),
    .DDS_delta_rate (DDS_delta_rate),
    .DDS_START      (DDS_START),
    .RUN            (RUN),
    .FREQ_WORD      (FREQ_WORD),
    .PHASE_OUT      (PHASE_OUT),
    .PARAM_NEW      (PARAM_NEW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: last parameter set handed over, and the chirp in progress.
  logic [FW-1:0] sh_f, sh_df;
  logic [RW-1:0] sh_dr;
  logic [FW-1:0] m_f0, m_df, m_phase, frozen;
  logic [RW-1:0] m_dr;
  longint unsigned m_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Frequency after n cycles of running: one step of delta_freq every delta_rate cycles.
  function automatic logic [FW-1:0] fexp(input longint unsigned n);
    logic [FW-1:0] steps;
    if (m_dr == '0) return m_f0;
    steps = FW'(n / longint'(m_dr));
    return m_f0 + m_df * steps;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " run"}, 64'(RUN), 64'd1);
    chk({tag, " freq"}, 64'(FREQ_WORD), 64'(fexp(m_n)));
    chk({tag, " phase"}, 64'(PHASE_OUT), 64'(m_phase[FW-1 -: PW]));
    m_phase = m_phase + fexp(m_n);
    m_n++;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [FW-1:0] df, input logic [RW-1:0] dr);
    int pn;
    int i;
    pn = 0;
    DDS_freq = f;
    DDS_delta_freq = df;
    DDS_delta_rate = dr;
    REQ = 1'b1;
    for (i = 0; i < 20 && !ACK; i++) begin
      tick;
      pn += int'(PARAM_NEW);
    end
    chk("send ack high", 64'(ACK), 64'd1);
    REQ = 1'b0;
    for (i = 0; i < 20 && ACK; i++) begin
      tick;
      pn += int'(PARAM_NEW);
    end
    chk("send ack low", 64'(ACK), 64'd0);
    chk("send param_new count", 64'(pn), 64'd1);
    sh_f = f;
    sh_df = df;
    sh_dr = dr;
  endtask

  task automatic start_run;
    m_f0 = sh_f;
    m_df = sh_df;
    m_dr = sh_dr;
    m_n = 0;
    m_phase = '0;
    DDS_START = 1'b1;
    tick;
    chk("start lat0", 64'(RUN), 64'd0);
    tick;
    chk("start lat1", 64'(RUN), 64'd0);
    tick;
    check_model("start");
  endtask

  // Runs n cycles against the model, optionally sending a new parameter set meanwhile.
  task automatic run_cycles(input int n, input bit with_req, input logic [FW-1:0] f,
                            input logic [FW-1:0] df, input logic [RW-1:0] dr);
    if (with_req) begin
      DDS_freq = f;
      DDS_delta_freq = df;
      DDS_delta_rate = dr;
      REQ = 1'b1;
    end
    repeat (n) begin
      tick;
      check_model("run");
      if (REQ && ACK) REQ = 1'b0;
    end
    if (with_req) begin
      chk("run capture done", 64'({REQ, ACK}), 64'd0);
      sh_f = f;
      sh_df = df;
      sh_dr = dr;
    end
  endtask

  task automatic stop_run;
    DDS_START = 1'b0;
    tick;
    check_model("stop0");
    tick;
    check_model("stop1");
    frozen = fexp(m_n - 1);
    tick;
    chk("stop run", 64'(RUN), 64'd0);
    chk("stop freq frozen", 64'(FREQ_WORD), 64'(frozen));
    tick;
    chk("stop phase zero", 64'(PHASE_OUT), 64'd0);
    chk("stop freq held", 64'(FREQ_WORD), 64'(frozen));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int pn;
    logic [FW-1:0] k0;

    sh_f = '0; sh_df = '0; sh_dr = '0;
    m_f0 = '0; m_df = '0; m_dr = '0; m_n = 0; m_phase = '0; frozen = '0;

    repeat (3) tick;
    chk("reset ack", 64'(ACK), 64'd0);
    chk("reset run", 64'(RUN), 64'd0);
    chk("reset freq", 64'(FREQ_WORD), 64'd0);
    chk("reset phase", 64'(PHASE_OUT), 64'd0);
    chk("reset param_new", 64'(PARAM_NEW), 64'd0);
    RESETn = 1'b1;
    tick;

    // Basic handshake with exact latency
    DDS_freq = 48'h0001_0000_0000;
    DDS_delta_freq = 48'h10;
    DDS_delta_rate = 32'd4;
    REQ = 1'b1;
    pn = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hs rise ack", 64'(ACK), 64'd0);
      chk("hs param_new", 64'(PARAM_NEW), 64'(i == 2));
      pn += int'(PARAM_NEW);
    end
    tick;
    chk("hs ack high", 64'(ACK), 64'd1);
    pn += int'(PARAM_NEW);
    repeat (5) begin
      tick;
      chk("hs ack holds", 64'(ACK), 64'd1);
      pn += int'(PARAM_NEW);
    end
    REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hs fall ack", 64'(ACK), 64'd1);
      pn += int'(PARAM_NEW);
    end
    tick;
    chk("hs ack low", 64'(ACK), 64'd0);
    repeat (4) begin
      tick;
      pn += int'(PARAM_NEW);
    end
    chk("hs single param_new", 64'(pn), 64'd1);
    sh_f = 48'h0001_0000_0000; sh_df = 48'h10; sh_dr = 32'd4;

    // Directed sweep
    send(48'h1000, 48'h10, 32'd4);
    start_run;
    run_cycles(16, 1'b0, '0, '0, '0);
    chk("sweep fourth step", 64'(FREQ_WORD), 64'h1040);
    stop_run;

    // Randomised sweeps
    for (int r = 0; r < 4; r++) begin
      send({16'($urandom), $urandom}, 48'($urandom_range(1, 32'hFFFF)), 32'($urandom_range(1, 7)));
      start_run;
      run_cycles(int'($urandom_range(20, 60)), 1'b0, '0, '0, '0);
      stop_run;
    end

    // No sweep over 1000 cycles
    k0 = {16'($urandom), $urandom};
    send(k0, 48'h55, 32'd0);
    start_run;
    run_cycles(1000, 1'b0, '0, '0, '0);
    chk("nosweep constant", 64'(FREQ_WORD), 64'(k0));
    stop_run;

    // Wrap
    send(48'hFFFF_FFFF_FFF0, 48'h20, 32'd1);
    start_run;
    run_cycles(1, 1'b0, '0, '0, '0);
    chk("wrap value", 64'(FREQ_WORD), 64'h10);
    run_cycles(8, 1'b0, '0, '0, '0);
    stop_run;

    // Capture during run leaves the chirp alone, next start picks it up
    send(48'h1_0000, 48'h7, 32'd3);
    start_run;
    run_cycles(40, 1'b1, 48'h2000, 48'h10, 32'd3);
    stop_run;
    start_run;
    chk("restart freq", 64'(FREQ_WORD), 64'h2000);
    run_cycles(20, 1'b0, '0, '0, '0);
    stop_run;

    // Reset mid-handshake
    DDS_freq = 48'h3000;
    DDS_delta_freq = 48'h1;
    DDS_delta_rate = 32'd2;
    REQ = 1'b1;
    for (int i = 0; i < 20 && !ACK; i++) tick;
    chk("rst pre ack", 64'(ACK), 64'd1);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    chk("rst ack", 64'(ACK), 64'd0);
    chk("rst run", 64'(RUN), 64'd0);
    chk("rst freq", 64'(FREQ_WORD), 64'd0);
    chk("rst phase", 64'(PHASE_OUT), 64'd0);
    chk("rst param_new", 64'(PARAM_NEW), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst rise ack", 64'(ACK), 64'd0);
      chk("rst param_new pulse", 64'(PARAM_NEW), 64'(i == 2));
    end
    tick;
    chk("rst ack again", 64'(ACK), 64'd1);
    REQ = 1'b0;
    for (int i = 0; i < 20 && ACK; i++) tick;
    chk("rst ack drop", 64'(ACK), 64'd0);
    sh_f = 48'h3000; sh_df = 48'h1; sh_dr = 32'd2;
    start_run;
    run_cycles(10, 1'b0, '0, '0, '0);
    stop_run;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_chirp_rx.md
Name: dds_chirp_rx

Overview:
- DDS-clock-domain end of the REQ/ACK parameter link driven by the master start controller.
- Synchronises the incoming 4-phase request, captures the DDS frequency / delta-frequency / delta-rate bus into shadow registers and returns ACK.
- Runs the linear-FM chirp engine: frequency-sweep and phase accumulators gated by a synchronised DDS_START.
- Feeds the phase-to-amplitude stage of the FPGA DDS.

Parameters:
- SYNC_STAGES, 2, flops in each async-input synchroniser (REQ, DDS_START); minimum 2.
- FREQ_W, 48, width of frequency, delta-frequency and phase accumulators.
- RATE_W, 32, width of the delta-rate (sweep period) word.
- PHASE_OUT_W, 16, MSBs of phase accumulator presented on PHASE_OUT.

Ports:
- CLK  in  1  DDS clock; sole clock of the block.
- RESETn  in  1  reset, asynchronous, active-low.
- REQ  in  1  request from the sender's domain, asynchronous; data bus stable while high.
- ACK  out  1  acknowledge back to sender, registered.
- DDS_freq  in  FREQ_W  start frequency word; quasi-static, valid while REQ high.
- DDS_delta_freq  in  FREQ_W  frequency increment per sweep step.
- DDS_delta_rate  in  RATE_W  CLK cycles per sweep step; 0 = no sweep.
- DDS_START  in  1  run enable from the sender's domain, asynchronous, level.
- RUN  out  1  synchronised run state.
- FREQ_WORD  out  FREQ_W  current instantaneous frequency word.
- PHASE_OUT  out  PHASE_OUT_W  phase accumulator MSBs.
- PARAM_NEW  out  1  one-cycle pulse when a new parameter set is captured.

Behaviour:
- Reset (RESETn=0, async): ACK=0, RUN=0, FREQ_WORD=0, PHASE_OUT=0, PARAM_NEW=0. All shadow regs, active regs, phase and rate counter = 0. Handshake FSM returns to H_IDLE.
- Synchronisers: SYNC_STAGES-flop chains on REQ -> req_s and DDS_START -> start_s. No other async input is sampled directly.
- Bus sampling: DDS_* buses are sampled only in the cycle of the H_IDLE->H_ACK transition, when req_s is already high. The sender guarantees bus stability from REQ rise until ACK is seen high.
- Handshake FSM:
  - H_IDLE: ACK=0. On req_s=1: capture DDS_freq, DDS_delta_freq and DDS_delta_rate into shadow regs; pulse PARAM_NEW; go to H_ACK.
  - H_ACK: ACK=1. On req_s=0: go to H_IDLE.
  - ACK is registered from the state.
- Latency: REQ first sampled high at edge k -> ACK=1 after edge k+SYNC_STAGES+1, i.e. k+3 with the default. REQ low -> ACK low with the same latency.
- Return-to-zero: ACK stays high while REQ stays high. No second capture until a full REQ low/high cycle.
- Reset mid-handshake: ACK drops immediately. If REQ is still high after reset release, a fresh capture occurs; this is idempotent for the sender.
- Start edge detect: start_s rising -> next cycle:
  - RUN=1;
  - active freq <= shadow freq;
  - active delta_freq/delta_rate <= shadow values;
  - phase <= 0;
  - rate counter <= shadow delta_rate.
- start_s falling: RUN=0; FREQ_WORD holds its last value; phase cleared to 0 next cycle and held while RUN=0.
- Sweep (RUN=1, active delta_rate != 0):
  - Rate counter decrements each cycle.
  - When the counter is 1, FREQ_WORD <= FREQ_WORD + delta_freq (mod 2^FREQ_W, wraps silently) and the counter reloads delta_rate.
  - Step period = delta_rate cycles exactly.
- Sweep disabled: active delta_rate = 0 -> FREQ_WORD constant; counter held at 0.
- Phase (RUN=1): phase <= phase + FREQ_WORD each cycle, mod 2^FREQ_W. PHASE_OUT = phase[FREQ_W-1 -: PHASE_OUT_W].
- Capture while RUN=1: only shadow regs update; the running chirp is unaffected. New values apply at the next start_s rising edge. This supports coherent bursts where DDS_START stays high.
- Capture and start rise in the same cycle: the start load takes the previous shadow values. The newly captured set applies from the next start.

Decomposition:
- Shared package dds_pkg:
  - FREQ_W and RATE_W constants;
  - typedef dds_param_t struct {freq, delta_freq, delta_rate};
  - handshake state enum {H_IDLE, H_ACK}.
- The sender side uses the same package.
- One natural sub-module: sync_bit (SYNC_STAGES flop chain, async active-low reset to 0), instantiated twice.

Test Plan:
- Basic handshake: REQ=1 with freq=0x000100000000, delta_freq=0x10, delta_rate=4 -> ACK=1 exactly 3 cycles after REQ sampled; PARAM_NEW one pulse. Drop REQ -> ACK=0 3 cycles later; no second PARAM_NEW.
- Sweep: after capture of freq=0x1000, delta_freq=0x10, delta_rate=4, assert DDS_START -> RUN=1 and FREQ_WORD=0x1000, then 0x1010, 0x1020, 0x1030 at exactly 4-cycle steps. PHASE accumulates the sum of FREQ_WORD values.
- No sweep and wrap: delta_rate=0 -> FREQ_WORD constant over 1000 cycles. freq=0xFFFFFFFFFFF0, delta_freq=0x20, delta_rate=1 -> FREQ_WORD wraps to 0x000000000010.
- Capture during run: while RUN=1 send freq=0x2000 -> FREQ_WORD sweep continues unchanged. Toggle DDS_START low/high -> restarts at 0x2000 with phase from 0.
- Reset mid-handshake: pull RESETn low while ACK=1 and REQ held high -> ACK=0 and all outputs 0 immediately. After release, ACK=1 again after 3 cycles with a fresh PARAM_NEW.
- Stop: drop DDS_START mid-sweep -> RUN=0 after sync latency; FREQ_WORD frozen; PHASE_OUT=0 the following cycle.
